// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute over 3-5 states,
// stretches memory states on mem_ready and traps on illegal opcodes or memory timeouts.
module mips_mc_ctrl #(
  parameter int TRAP_ON_ILLEGAL = 1,
  parameter int MAX_WAIT        = 16,
  parameter int WAIT_W          = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       memread,
  output logic       memwrite,
  output logic       iord,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       extop,
  output logic [1:0] pcsrc,
  output logic       pcen,
  output logic [3:0] alucontrol,
  output logic       illegal,
  output logic       bus_err,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_IMMEX   = 4'd9,
    S_IMMWB   = 4'd10,
    S_JUMP    = 4'd11,
    S_TRAP    = 4'd12
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_AND = 4'b0100;
  localparam logic [3:0] ALU_OR  = 4'b0101;
  localparam logic [3:0] ALU_SLT = 4'b1010;

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  state_t            cur, nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              set_ill, set_bus;
  logic              r_ok, mem_state, timeout;
  logic [3:0]        r_alu;
  logic              memread_s, memwrite_s, irwrite_s, regwrite_s, pcen_s;

  always_comb begin
    r_ok  = 1'b1;
    r_alu = ALU_ADD;
    case (funct)
      6'b100000: r_alu = ALU_ADD;
      6'b100010: r_alu = ALU_SUB;
      6'b100100: r_alu = ALU_AND;
      6'b100101: r_alu = ALU_OR;
      6'b101010: r_alu = ALU_SLT;
      default:   r_ok  = 1'b0;
    endcase
  end

  assign mem_state = (cur == S_FETCH) || (cur == S_MEMRD) || (cur == S_MEMWR);
  assign timeout   = (MAX_WAIT != 0) && mem_state && !mem_ready && (wait_cnt == WAIT_LAST);

  always_comb begin
    nxt        = cur;
    set_ill    = 1'b0;
    set_bus    = 1'b0;
    memread_s  = 1'b0;
    memwrite_s = 1'b0;
    irwrite_s  = 1'b0;
    regwrite_s = 1'b0;
    pcen_s     = 1'b0;
    iord       = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    extop      = 1'b0;
    pcsrc      = 2'b00;
    alucontrol = ALU_ADD;
    case (cur)
      S_FETCH: begin
        memread_s = 1'b1;
        alusrcb   = 2'b01;
        irwrite_s = mem_ready;
        pcen_s    = mem_ready;
        if (mem_ready) nxt = S_DECODE;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_R:                             nxt = r_ok ? S_EXECUTE : S_TRAP;
          OP_LW, OP_SW:                     nxt = S_MEMADR;
          OP_BEQ, OP_BNE:                   nxt = S_BRANCH;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: nxt = S_IMMEX;
          OP_J:                             nxt = S_JUMP;
          default:                          nxt = S_TRAP;
        endcase
        // S_TRAP above is only a marker for "unrecognised"; the parameter picks trap or NOP
        if (nxt == S_TRAP) begin
          if (TRAP_ON_ILLEGAL != 0) set_ill = 1'b1;
          else                      nxt     = S_FETCH;
        end
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        nxt     = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        memread_s = 1'b1;
        iord      = 1'b1;
        if (mem_ready) nxt = S_MEMWB;
      end
      S_MEMWB: begin
        memtoreg   = 1'b1;
        regwrite_s = 1'b1;
        nxt        = S_FETCH;
      end
      S_MEMWR: begin
        memwrite_s = 1'b1;
        iord       = 1'b1;
        if (mem_ready) nxt = S_FETCH;
      end
      S_EXECUTE: begin
        alusrca    = 1'b1;
        alucontrol = r_alu;
        nxt        = S_ALUWB;
      end
      S_ALUWB: begin
        regdst     = 1'b1;
        regwrite_s = 1'b1;
        nxt        = S_FETCH;
      end
      S_BRANCH: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        pcsrc      = 2'b01;
        pcen_s     = (op == OP_BNE) ? ~zero : zero;
        nxt        = S_FETCH;
      end
      S_IMMEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        case (op)
          OP_SLTI: alucontrol = ALU_SLT;
          OP_ANDI: alucontrol = ALU_AND;
          OP_ORI:  alucontrol = ALU_OR;
          default: alucontrol = ALU_ADD;
        endcase
        extop = (op == OP_ANDI) || (op == OP_ORI);
        nxt   = S_IMMWB;
      end
      S_IMMWB: begin
        regwrite_s = 1'b1;
        nxt        = S_FETCH;
      end
      S_JUMP: begin
        pcsrc  = 2'b10;
        pcen_s = 1'b1;
        nxt    = S_FETCH;
      end
      S_TRAP:  nxt = S_TRAP;
      default: nxt = S_FETCH;
    endcase
    if (timeout) begin
      nxt     = S_TRAP;
      set_bus = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur      <= S_FETCH;
      wait_cnt <= '0;
      illegal  <= 1'b0;
      bus_err  <= 1'b0;
    end else begin
      cur     <= nxt;
      illegal <= illegal | set_ill;
      bus_err <= bus_err | set_bus;
      if (nxt != cur)
        wait_cnt <= '0;
      else if (mem_state && !mem_ready && wait_cnt != '1)
        wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign memread  = memread_s  & ~reset;
  assign memwrite = memwrite_s & ~reset;
  assign irwrite  = irwrite_s  & ~reset;
  assign regwrite = regwrite_s & ~reset;
  assign pcen     = pcen_s     & ~reset;
  assign state    = cur;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Randomized bench for mips_mc_ctrl: a per-instruction trace planner predicts every
// cycle's state and outputs; two instances cover trap/timeout and NOP/no-timeout builds.
module tb_mips_mc_ctrl;

  typedef struct packed {
    logic       memread, memwrite, iord, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb;
    logic       extop;
    logic [1:0] pcsrc;
    logic       pcen;
    logic [3:0] alucontrol;
    logic       illegal, bus_err;
  } ov_t;

  typedef struct {
    logic       rst;
    logic       mr;
    logic [3:0] st;
    ov_t        o;
  } cyc_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op = '0, funct = '0;
  logic       zero = 1'b0, mem_ready = 1'b1;

  logic       a_memread, a_memwrite, a_iord, a_irwrite, a_regdst, a_memtoreg, a_regwrite, a_alusrca;
  logic [1:0] a_alusrcb, a_pcsrc;
  logic       a_extop, a_pcen, a_illegal, a_bus_err;
  logic [3:0] a_alucontrol, a_state;
  logic       b_memread, b_memwrite, b_iord, b_irwrite, b_regdst, b_memtoreg, b_regwrite, b_alusrca;
  logic [1:0] b_alusrcb, b_pcsrc;
  logic       b_extop, b_pcen, b_illegal, b_bus_err;
  logic [3:0] b_alucontrol, b_state;

  mips_mc_ctrl #(.TRAP_ON_ILLEGAL(1), .MAX_WAIT(4), .WAIT_W(8)) dut_a (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .memread(a_memread), .memwrite(a_memwrite), .iord(a_iord), .irwrite(a_irwrite),
    .regdst(a_regdst), .memtoreg(a_memtoreg), .regwrite(a_regwrite), .alusrca(a_alusrca),
    .alusrcb(a_alusrcb), .extop(a_extop), .pcsrc(a_pcsrc), .pcen(a_pcen),
    .alucontrol(a_alucontrol), .illegal(a_illegal), .bus_err(a_bus_err), .state(a_state)
  );

  mips_mc_ctrl #(.TRAP_ON_ILLEGAL(0), .MAX_WAIT(0), .WAIT_W(8)) dut_b (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .memread(b_memread), .memwrite(b_memwrite), .iord(b_iord), .irwrite(b_irwrite),
    .regdst(b_regdst), .memtoreg(b_memtoreg), .regwrite(b_regwrite), .alusrca(b_alusrca),
    .alusrcb(b_alusrcb), .extop(b_extop), .pcsrc(b_pcsrc), .pcen(b_pcen),
    .alucontrol(b_alucontrol), .illegal(b_illegal), .bus_err(b_bus_err), .state(b_state)
  );

  always #5 clk = ~clk;

  int   n_chk = 0;
  int   n_err = 0;
  bit   dsel  = 1'b0;   // 0 = dut_a, 1 = dut_b
  bit   tr_on = 1'b1;   // model of TRAP_ON_ILLEGAL for the selected instance
  int   mw    = 4;      // model of MAX_WAIT for the selected instance
  logic m_ill, m_bus;
  cyc_t plan[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  function automatic ov_t observed();
    ov_t o;
    if (dsel)
      o = '{b_memread, b_memwrite, b_iord, b_irwrite, b_regdst, b_memtoreg, b_regwrite, b_alusrca,
            b_alusrcb, b_extop, b_pcsrc, b_pcen, b_alucontrol, b_illegal, b_bus_err};
    else
      o = '{a_memread, a_memwrite, a_iord, a_irwrite, a_regdst, a_memtoreg, a_regwrite, a_alusrca,
            a_alusrcb, a_extop, a_pcsrc, a_pcen, a_alucontrol, a_illegal, a_bus_err};
    return o;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Instruction class: 0 R, 1 LW, 2 SW, 3 branch, 4 imm-ALU, 5 J, 6 unrecognised
  function automatic int kind(input logic [5:0] o, input logic [5:0] f);
    case (o)
      6'h00:                      return (f inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2a}) ? 0 : 6;
      6'h23:                      return 1;
      6'h2b:                      return 2;
      6'h04, 6'h05:               return 3;
      6'h08, 6'h0a, 6'h0c, 6'h0d: return 4;
      6'h02:                      return 5;
      default:                    return 6;
    endcase
  endfunction

  function automatic logic [3:0] r_alu(input logic [5:0] f);
    case (f)
      6'h22:   return 4'd2;
      6'h24:   return 4'd4;
      6'h25:   return 4'd5;
      6'h2a:   return 4'd10;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [3:0] i_alu(input logic [5:0] o);
    case (o)
      6'h0a:   return 4'd10;
      6'h0c:   return 4'd4;
      6'h0d:   return 4'd5;
      default: return 4'd0;
    endcase
  endfunction

  task automatic push(input logic mr, input logic [3:0] st, input ov_t o);
    cyc_t c;
    o.illegal = m_ill;
    o.bus_err = m_bus;
    c.rst = 1'b0; c.mr = mr; c.st = st; c.o = o;
    plan.push_back(c);
  endtask

  // w cycles without ready then one ready cycle, unless the timeout fires first
  task automatic mem_phase(input int w, input logic [3:0] st, input ov_t busy, input ov_t done,
                           output bit to);
    int n;
    to = (mw != 0) && (w >= mw);
    n  = to ? mw : w;
    for (int i = 0; i < n; i++) push(1'b0, st, busy);
    if (!to) push(1'b1, st, done);
  endtask

  task automatic plan_instr(input logic [5:0] iop, input logic [5:0] ifn, input logic iz,
                            input int wf, input int wm, input int ntrap, input int rst_at);
    ov_t  o, d;
    bit   to, trapped;
    cyc_t c;
    plan.delete();
    m_ill = 1'b0; m_bus = 1'b0; trapped = 1'b0;
    o = '0; o.memread = 1'b1; o.alusrcb = 2'b01;
    d = o;  d.irwrite = 1'b1; d.pcen = 1'b1;
    mem_phase(wf, 4'd0, o, d, to);
    if (!to) begin
      o = '0; o.alusrcb = 2'b11; push(rb(), 4'd1, o);
      case (kind(iop, ifn))
        0: begin
          o = '0; o.alusrca = 1'b1; o.alucontrol = r_alu(ifn); push(rb(), 4'd6, o);
          o = '0; o.regdst = 1'b1; o.regwrite = 1'b1;          push(rb(), 4'd7, o);
        end
        1, 2: begin
          o = '0; o.alusrca = 1'b1; o.alusrcb = 2'b10; push(rb(), 4'd2, o);
          if (iop == 6'h23) begin
            o = '0; o.memread = 1'b1; o.iord = 1'b1;
            mem_phase(wm, 4'd3, o, o, to);
            if (!to) begin
              o = '0; o.memtoreg = 1'b1; o.regwrite = 1'b1; push(rb(), 4'd4, o);
            end
          end else begin
            o = '0; o.memwrite = 1'b1; o.iord = 1'b1;
            mem_phase(wm, 4'd5, o, o, to);
          end
        end
        3: begin
          o = '0; o.alusrca = 1'b1; o.alucontrol = 4'd2; o.pcsrc = 2'b01;
          o.pcen = (iop == 6'h05) ? ~iz : iz;
          push(rb(), 4'd8, o);
        end
        4: begin
          o = '0; o.alusrca = 1'b1; o.alusrcb = 2'b10; o.alucontrol = i_alu(iop);
          o.extop = (iop == 6'h0c) || (iop == 6'h0d);
          push(rb(), 4'd9, o);
          o = '0; o.regwrite = 1'b1; push(rb(), 4'd10, o);
        end
        5: begin
          o = '0; o.pcsrc = 2'b10; o.pcen = 1'b1; push(rb(), 4'd11, o);
        end
        default: if (tr_on) begin m_ill = 1'b1; trapped = 1'b1; end
      endcase
    end
    if (to) begin m_bus = 1'b1; trapped = 1'b1; end
    if (trapped) begin
      for (int i = 0; i <= ntrap; i++) push(rb(), 4'd12, '0);
      c = plan[plan.size() - 1];
      c.rst = 1'b1;
      plan.push_back(c);
    end
    if (rst_at >= 0 && rst_at < plan.size()) begin
      while (plan.size() > rst_at + 1) void'(plan.pop_back());
      plan[rst_at].rst = 1'b1;
    end
    foreach (plan[i]) if (plan[i].rst) begin
      plan[i].o.memread = 1'b0; plan[i].o.memwrite = 1'b0; plan[i].o.irwrite = 1'b0;
      plan[i].o.regwrite = 1'b0; plan[i].o.pcen = 1'b0;
    end
    op = iop; funct = ifn; zero = iz;
  endtask

  task automatic run_plan(input string tag);
    cyc_t c;
    while (plan.size() > 0) begin
      c = plan.pop_front();
      reset = c.rst;
      mem_ready = c.mr;
      @(negedge clk);
      chk({tag, ".state"}, {28'd0, (dsel ? b_state : a_state)}, {28'd0, c.st});
      chk({tag, ".outs"}, {12'd0, observed()}, {12'd0, c.o});
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
  endtask

  task automatic do_instr(input string tag, input logic [5:0] iop, input logic [5:0] ifn,
                          input logic iz, input int wf, input int wm, input int ntrap,
                          input int rst_at);
    plan_instr(iop, ifn, iz, wf, wm, ntrap, rst_at);
    run_plan(tag);
  endtask

  task automatic reset_check();
    ov_t e;
    reset = 1'b1; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    e = '0; e.alusrcb = 2'b01;
    chk("reset.state", {28'd0, (dsel ? b_state : a_state)}, 32'd0);
    chk("reset.outs", {12'd0, observed()}, {12'd0, e});
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic rand_instr(input int wmax);
    logic [5:0] o, f;
    int r, wf, wm, rst_at;
    r = $urandom_range(0, 15);
    f = 6'($urandom_range(0, 63));
    case (r % 5)
      0: f = 6'h20; 1: f = 6'h22; 2: f = 6'h24; 3: f = 6'h25; default: f = 6'h2a;
    endcase
    case (r)
      0, 1, 2, 14: o = 6'h00;
      3: begin o = 6'h00; f = 6'($urandom_range(0, 63)); end
      4, 15: o = 6'h23;
      5:  o = 6'h2b;
      6:  o = 6'h04;
      7:  o = 6'h05;
      8:  o = 6'h08;
      9:  o = 6'h0a;
      10: o = 6'h0c;
      11: o = 6'h0d;
      12: o = 6'h02;
      default: o = 6'($urandom_range(0, 63));
    endcase
    wf = ($urandom_range(0, 3) == 0) ? $urandom_range(0, wmax) : 0;
    wm = ($urandom_range(0, 2) == 0) ? $urandom_range(0, wmax) : 0;
    rst_at = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 7) : -1;
    do_instr("rand", o, f, rb(), wf, wm, $urandom_range(0, 3), rst_at);
  endtask

  initial begin
    // instance A: TRAP_ON_ILLEGAL=1, MAX_WAIT=4
    dsel = 1'b0; tr_on = 1'b1; mw = 4;
    reset_check();
    do_instr("r_add",     6'h00, 6'h20, 1'b0, 0, 0, 0, -1);
    do_instr("lw_wait3",  6'h23, 6'h00, 1'b0, 0, 3, 0, -1);
    do_instr("bne_z0",    6'h05, 6'h00, 1'b0, 0, 0, 0, -1);
    do_instr("bne_z1",    6'h05, 6'h00, 1'b1, 0, 0, 0, -1);
    do_instr("beq_z0",    6'h04, 6'h00, 1'b0, 0, 0, 0, -1);
    do_instr("beq_z1",    6'h04, 6'h00, 1'b1, 0, 0, 0, -1);
    do_instr("ori",       6'h0d, 6'h00, 1'b0, 0, 0, 0, -1);
    do_instr("ill_trap",  6'h3f, 6'h00, 1'b0, 0, 0, 20, -1);
    do_instr("fetch_to",  6'h00, 6'h20, 1'b0, 4, 0, 3, -1);
    do_instr("fetch_w3",  6'h08, 6'h00, 1'b0, 3, 0, 0, -1);
    do_instr("sw_rst",    6'h2b, 6'h00, 1'b0, 0, 2, 0, 3);
    do_instr("lw_to",     6'h23, 6'h00, 1'b0, 0, 4, 2, -1);
    do_instr("r_badfn",   6'h00, 6'h3f, 1'b0, 0, 0, 2, -1);
    for (int i = 0; i < 300; i++) rand_instr(6);

    // instance B: TRAP_ON_ILLEGAL=0, timeout disabled
    dsel = 1'b1; tr_on = 1'b0; mw = 0;
    reset_check();
    do_instr("b_ill_nop", 6'h3f, 6'h00, 1'b0, 0, 0, 0, -1);
    do_instr("b_badfn",   6'h00, 6'h01, 1'b0, 0, 0, 0, -1);
    do_instr("b_longw",   6'h23, 6'h00, 1'b0, 30, 20, 0, -1);
    for (int i = 0; i < 150; i++) rand_instr(12);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
